// File: rtl/mac_merge_pkg.sv
// Shared MAC Merge definitions: transmit byte-port states and the reflected CRC-32
// byte step used by both the transmit mCRC generator and the receive-side checker.
package mac_merge_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_DATA,
        TX_MCRC,
        TX_CPLT,
        TX_IPG
    } rtx_state_e;

    localparam logic [31:0] CRC32_POLY       = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;
    localparam logic [31:0] MCRC_XOR_DEFAULT = 32'h0000FFFF;

    // One byte of reflected CRC-32, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_merge_rtx_byte_port_if.sv
// Byte stream from the transmit processing state diagram plus the GMII-side outputs.
interface mac_merge_rtx_byte_port_if;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       crc_en;
    logic       crc_clear;
    logic       mcrc_req;
    logic       cplt_req;
    logic       ipg_start;
    logic       byte_ready;
    logic       rTXByteSent;
    logic       mCRC_sent;
    logic       data_complete_sent;
    logic       ipg_timer_done;
    logic [7:0] txd;
    logic       tx_en;

    modport master (
        output tx_byte, tx_byte_valid, crc_en, crc_clear, mcrc_req, cplt_req, ipg_start,
        input  byte_ready, rTXByteSent, mCRC_sent, data_complete_sent, ipg_timer_done, txd, tx_en
    );

    modport slave (
        input  tx_byte, tx_byte_valid, crc_en, crc_clear, mcrc_req, cplt_req, ipg_start,
        output byte_ready, rTXByteSent, mCRC_sent, data_complete_sent, ipg_timer_done, txd, tx_en
    );
endinterface

// File: rtl/mac_merge_ipg_counter.sv
// Inter-packet gap timer: counts idle byte times (tx_en low) after a start, holding
// while the wire is still busy, and raises ipg_timer_done after IPG_BYTES of them.
module mac_merge_ipg_counter #(
    parameter int IPG_BYTES = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic ipg_start,
    input  logic tx_en,
    output logic ipg_timer_done
);

    localparam logic [7:0] IPG_LAST = 8'(IPG_BYTES);

    logic [7:0] ipgCnt;

    // The start cycle itself is counted when the wire is already idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipgCnt         <= 8'd0;
            ipg_timer_done <= 1'b1;
        end else if (ipg_start) begin
            ipgCnt         <= tx_en ? 8'd0 : 8'd1;
            ipg_timer_done <= !tx_en && (IPG_LAST == 8'd1);
        end else if (!ipg_timer_done && !tx_en) begin
            ipgCnt         <= ipgCnt + 8'd1;
            ipg_timer_done <= (ipgCnt + 8'd1) == IPG_LAST;
        end
    end

endmodule

// File: rtl/mac_merge_rtx_byte_port.sv
// Transmit byte port behind the MAC Merge transmit processing: registers bytes onto
// txd/tx_en, appends the 4-byte mCRC, closes fragments and times the IPG.
module mac_merge_rtx_byte_port
    import mac_merge_pkg::*;
#(
    parameter int          IPG_BYTES = 12,
    parameter logic [31:0] MCRC_XOR  = MCRC_XOR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    mac_merge_rtx_byte_port_if.slave   bus
);

    rtx_state_e  state, stateNext;
    logic [7:0]  txdQ, txdNext;
    logic        txEnQ, txEnNext;
    logic        sentQ, sentNext;
    logic        mcrcSentQ, mcrcSentNext;
    logic        dcsQ, dcsNext;
    logic [31:0] crc, crcNext;
    logic [31:0] mReg, mRegNext;
    logic [2:0]  mIdx, mIdxNext;
    logic        cpltPend, cpltPendNext;
    logic        ipgKick;
    logic        ipgDone;
    logic        byteReady;
    logic        accept;
    logic [31:0] crcBase;
    logic [31:0] crcAcc;
    logic [31:0] mVal;

    assign byteReady = (state == TX_IDLE) || (state == TX_DATA) || ((state == TX_IPG) && ipgDone);
    assign accept    = bus.tx_byte_valid && byteReady;

    // Clear is applied ahead of the byte it arrives with.
    assign crcBase = bus.crc_clear ? CRC32_INIT : crc;
    assign crcAcc  = bus.crc_en ? crc32_byte(crcBase, bus.tx_byte) : crcBase;
    assign mVal    = ~(accept ? crcAcc : crc) ^ MCRC_XOR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= TX_IDLE;
            txdQ      <= 8'h00;
            txEnQ     <= 1'b0;
            sentQ     <= 1'b0;
            mcrcSentQ <= 1'b0;
            dcsQ      <= 1'b0;
            crc       <= CRC32_INIT;
            mReg      <= 32'h0;
            mIdx      <= 3'd0;
            cpltPend  <= 1'b0;
        end else begin
            state     <= stateNext;
            txdQ      <= txdNext;
            txEnQ     <= txEnNext;
            sentQ     <= sentNext;
            mcrcSentQ <= mcrcSentNext;
            dcsQ      <= dcsNext;
            crc       <= crcNext;
            mReg      <= mRegNext;
            mIdx      <= mIdxNext;
            cpltPend  <= cpltPendNext;
        end
    end

    always_comb begin
        stateNext    = state;
        txdNext      = 8'h00;
        txEnNext     = 1'b0;
        sentNext     = 1'b0;
        mcrcSentNext = 1'b0;
        dcsNext      = 1'b0;
        crcNext      = crc;
        mRegNext     = mReg;
        mIdxNext     = mIdx;
        cpltPendNext = cpltPend;
        ipgKick      = 1'b0;

        if (accept) begin
            txdNext  = bus.tx_byte;
            txEnNext = 1'b1;
            sentNext = 1'b1;
            crcNext  = crcAcc;
        end

        case (state)
            TX_IDLE: begin
                if (accept) stateNext = TX_DATA;
            end
            TX_IPG: begin
                if (accept)       stateNext = TX_DATA;
                else if (ipgDone) stateNext = TX_IDLE;
            end
            TX_DATA: begin
                if (bus.mcrc_req) begin
                    // A concurrent cplt_req is absorbed: MCRC always closes into CPLT.
                    mRegNext     = mVal;
                    crcNext      = CRC32_INIT;
                    cpltPendNext = 1'b0;
                    stateNext    = TX_MCRC;
                    if (accept) begin
                        mIdxNext = 3'd0;
                    end else begin
                        txdNext  = mVal[7:0];
                        txEnNext = 1'b1;
                        mIdxNext = 3'd1;
                    end
                end else if (bus.cplt_req || cpltPend) begin
                    // Let a byte accepted alongside the request go out first.
                    if (accept) begin
                        cpltPendNext = 1'b1;
                    end else begin
                        stateNext    = TX_CPLT;
                        dcsNext      = 1'b1;
                        crcNext      = CRC32_INIT;
                        cpltPendNext = 1'b0;
                        ipgKick      = 1'b1;
                    end
                end
            end
            TX_MCRC: begin
                if (mIdx != 3'd4) begin
                    txdNext      = mReg[{mIdx[1:0], 3'b000} +: 8];
                    txEnNext     = 1'b1;
                    mcrcSentNext = (mIdx == 3'd3);
                    mIdxNext     = mIdx + 3'd1;
                end else begin
                    stateNext = TX_CPLT;
                    dcsNext   = 1'b1;
                    crcNext   = CRC32_INIT;
                    ipgKick   = 1'b1;
                end
            end
            TX_CPLT: begin
                stateNext = TX_IPG;
            end
            default: begin
                stateNext = TX_IDLE;
            end
        endcase
    end

    mac_merge_ipg_counter #(
        .IPG_BYTES (IPG_BYTES)
    ) uIpg (
        .clk            (clk),
        .reset          (reset),
        .ipg_start      (bus.ipg_start || ipgKick),
        .tx_en          (txEnQ),
        .ipg_timer_done (ipgDone)
    );

    assign bus.byte_ready         = byteReady;
    assign bus.rTXByteSent        = sentQ;
    assign bus.mCRC_sent          = mcrcSentQ;
    assign bus.data_complete_sent = dcsQ;
    assign bus.ipg_timer_done     = ipgDone;
    assign bus.txd                = txdQ;
    assign bus.tx_en              = txEnQ;

endmodule
